// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared board geometry, tile types, FSM state encoding
package board_pkg;

    localparam int BOARD_W    = 32;
    localparam int BOARD_H    = 24;
    localparam int DEF_DEPTH  = BOARD_W * BOARD_H;
    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

    typedef enum logic [3:0] {
        TILE_FLOOR  = 4'h0,
        TILE_WALL   = 4'h1,
        TILE_PELLET = 4'h2,
        TILE_PAC    = 4'h3,
        TILE_GHOST0 = 4'h4,
        TILE_GHOST1 = 4'h5,
        TILE_GHOST2 = 4'h6
    } tile_e;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_PLACE  = 4'd1,
        ST_IDLE   = 4'd2,
        ST_CHECK  = 4'd3,
        ST_FETCH  = 4'd4,
        ST_CLEAR  = 4'd5,
        ST_DRAW   = 4'd6,
        ST_UPDATE = 4'd7,
        ST_NEXT   = 4'd8,
        ST_COLL   = 4'd9
    } state_e;

    typedef logic [DEF_ADDR_W-1:0] loc_t;

endpackage

// File: rtl/board_init_sweeper.sv
// rtl/board_init_sweeper.sv - INIT address counter with delayed write address/valid
module board_init_sweeper #(
    parameter int DEPTH  = 768,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              clear_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] sweep_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              wr_valid_o,
    output logic              done_o
);
    // Counter must be able to hold DEPTH itself, which may need one more bit.
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]  sweep_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_valid_q;

    assign done_o     = (sweep_q == CNT_W'(DEPTH));
    assign sweep_o    = sweep_q[ADDR_W-1:0];
    assign wr_addr_o  = wr_addr_q;
    assign wr_valid_o = wr_valid_q;

    // Address counter plus one-cycle delay that lines the write up with ROM data.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            sweep_q    <= '0;
            wr_addr_q  <= '0;
            wr_valid_q <= 1'b0;
        end else begin
            wr_addr_q  <= sweep_q[ADDR_W-1:0];
            wr_valid_q <= en_i && !done_o;
            if (en_i && !done_o) begin
                sweep_q <= sweep_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_board_updater.sv
// rtl/sprite_board_updater.sv - board RAM writer for init, sprite placement and moves (option: SPRITE_UNDERLAY_EN)
module sprite_board_updater #(
    parameter int                            BOARD_W      = board_pkg::BOARD_W,
    parameter int                            BOARD_H      = board_pkg::BOARD_H,
    parameter int                            NUM_SPRITES  = 4,
    parameter int                            TYPE_W       = 4,
    parameter logic [TYPE_W-1:0]             FLOOR_TYPE   = '0,
    parameter logic [NUM_SPRITES*TYPE_W-1:0] SPRITE_TYPES = {4'h6, 4'h5, 4'h4, 4'h3},
    localparam int                           DEPTH        = BOARD_W * BOARD_H,
    localparam int                           ADDR_W       = $clog2(DEPTH),
    parameter logic [NUM_SPRITES*ADDR_W-1:0] HOME_LOCS    = {10'd305, 10'd304, 10'd303, 10'd495}
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          start,
    input  logic [NUM_SPRITES*ADDR_W-1:0] next_loc,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [TYPE_W-1:0]             rom_data,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [TYPE_W-1:0]             wr_data,
    output logic [NUM_SPRITES*ADDR_W-1:0] loc,
    output logic                          busy,
    output logic                          collision
);
    import board_pkg::*;

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    localparam logic [3:0] S_INIT   = ST_INIT;
    localparam logic [3:0] S_PLACE  = ST_PLACE;
    localparam logic [3:0] S_IDLE   = ST_IDLE;
    localparam logic [3:0] S_CHECK  = ST_CHECK;
`ifdef SPRITE_UNDERLAY_EN
    localparam logic [3:0] S_FETCH  = ST_FETCH;
`endif
    localparam logic [3:0] S_CLEAR  = ST_CLEAR;
    localparam logic [3:0] S_DRAW   = ST_DRAW;
    localparam logic [3:0] S_UPDATE = ST_UPDATE;
    localparam logic [3:0] S_NEXT   = ST_NEXT;
    localparam logic [3:0] S_COLL   = ST_COLL;

    logic [3:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] loc_q  [NUM_SPRITES];
    logic [ADDR_W-1:0] loc_d  [NUM_SPRITES];
    logic [ADDR_W-1:0] snap_q [NUM_SPRITES];
    logic [ADDR_W-1:0] snap_d [NUM_SPRITES];
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [TYPE_W-1:0] wr_data_q, wr_data_d;
    logic              coll_q, coll_d;
    logic              busy_q;

    logic [ADDR_W-1:0] sweep_addr;
    logic [ADDR_W-1:0] sweep_wr_addr;
    logic              sweep_wr_valid;
    logic              sweep_done;

    logic              moved;
    logic              last_idx;
    logic              hit;
    logic              pass_rom;

    board_init_sweeper #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sweeper (
        .clk        (clk),
        .clear_i    (reset | start),
        .en_i       (state_q == S_INIT),
        .sweep_o    (sweep_addr),
        .wr_addr_o  (sweep_wr_addr),
        .wr_valid_o (sweep_wr_valid),
        .done_o     (sweep_done)
    );

    // Per-sprite status: a move is needed only for an in-range tile that differs.
    always_comb begin
        moved    = (snap_q[idx_q] != loc_q[idx_q]) && (int'(snap_q[idx_q]) < DEPTH);
        last_idx = (idx_q == IDX_W'(NUM_SPRITES - 1));
        hit      = 1'b0;
        for (int k = 1; k < NUM_SPRITES; k++) begin
            if (loc_q[k] == loc_q[0]) begin
                hit = 1'b1;
            end
        end
    end

    // Next-state logic; registered outputs are decoded from the state being entered.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        loc_d     = loc_q;
        snap_d    = snap_q;
        coll_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;

        case (state_q)
            S_INIT: begin
                if (sweep_done) begin
                    state_d = S_PLACE;
                    idx_d   = '0;
                end
            end
            S_PLACE: begin
                if (last_idx) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (tick) begin
                    for (int k = 0; k < NUM_SPRITES; k++) begin
                        snap_d[k] = next_loc[k*ADDR_W +: ADDR_W];
                    end
                    idx_d   = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (moved) begin
`ifdef SPRITE_UNDERLAY_EN
                    state_d = (idx_q != '0) ? S_FETCH : S_CLEAR;
`else
                    state_d = S_CLEAR;
`endif
                end else begin
                    state_d = S_NEXT;
                end
            end
`ifdef SPRITE_UNDERLAY_EN
            S_FETCH:  state_d = S_CLEAR;
`endif
            S_CLEAR:  state_d = S_DRAW;
            S_DRAW:   state_d = S_UPDATE;
            S_UPDATE: begin
                loc_d[idx_q] = snap_q[idx_q];
                state_d      = S_NEXT;
            end
            S_NEXT: begin
                if (last_idx) begin
                    state_d = S_COLL;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_COLL:   state_d = S_IDLE;
            default:  state_d = S_INIT;
        endcase

        // Restart wins over anything in flight, so no half-finished move survives.
        if (start) begin
            state_d = S_INIT;
            idx_d   = '0;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                loc_d[k] = HOME_LOCS[k*ADDR_W +: ADDR_W];
            end
        end

        case (state_d)
            S_PLACE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = HOME_LOCS[int'(idx_d)*ADDR_W +: ADDR_W];
                wr_data_d = SPRITE_TYPES[int'(idx_d)*TYPE_W +: TYPE_W];
            end
            S_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = loc_q[idx_d];
                wr_data_d = FLOOR_TYPE;
            end
            S_DRAW: begin
                wr_en_d   = 1'b1;
                wr_addr_d = snap_d[idx_d];
                wr_data_d = SPRITE_TYPES[int'(idx_d)*TYPE_W +: TYPE_W];
            end
            S_COLL:  coll_d = hit;
            default: wr_en_d = 1'b0;
        endcase
    end

`ifdef SPRITE_UNDERLAY_EN
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    // FETCH points the ROM at the ghost's old tile so CLEAR can restore it.
    always_comb begin
        rom_addr_d = (state_d == S_FETCH) ? loc_q[idx_d] : '0;
    end

    // ROM address register for the underlay lookup.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_q <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_addr = (state_q == S_INIT) ? sweep_addr : rom_addr_q;
    assign pass_rom = (state_q == S_INIT) || ((state_q == S_CLEAR) && (idx_q != '0));
`else
    assign rom_addr = (state_q == S_INIT) ? sweep_addr : '0;
    assign pass_rom = (state_q == S_INIT);
`endif

    // ROM data is already registered, so it feeds the write port directly when used.
    assign wr_en     = (state_q == S_INIT) ? sweep_wr_valid : wr_en_q;
    assign wr_addr   = (state_q == S_INIT) ? sweep_wr_addr  : wr_addr_q;
    assign wr_data   = pass_rom ? rom_data : wr_data_q;
    assign busy      = busy_q;
    assign collision = coll_q;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_loc
        assign loc[g*ADDR_W +: ADDR_W] = loc_q[g];
    end

    // State, sprite bookkeeping and registered write/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_INIT;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            coll_q    <= 1'b0;
            busy_q    <= 1'b1;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                loc_q[k]  <= HOME_LOCS[k*ADDR_W +: ADDR_W];
                snap_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            coll_q    <= coll_d;
            busy_q    <= (state_d != S_IDLE);
            loc_q     <= loc_d;
            snap_q    <= snap_d;
        end
    end

endmodule

// File: tb/tb_sprite_board_updater.sv
// tb/tb_sprite_board_updater.sv - self-checking bench for sprite_board_updater on a 4x3 board
module tb_sprite_board_updater;

    localparam int NS    = 2;
    localparam int DEPTH = 12;
`ifdef SPRITE_UNDERLAY_EN
    localparam bit UNDERLAY = 1'b1;
`else
    localparam bit UNDERLAY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [7:0] next_loc = '0;
    logic [3:0] rom_addr;
    logic [3:0] rom_data = '0;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] loc;
    logic       busy;
    logic       collision;

    int checks = 0;
    int failures = 0;

    int stype [NS] = '{3, 4};
    int home  [NS] = '{1, 5};

    int ref_board [16];
    int ref_loc   [NS];

    logic [3:0] ram [16];
    logic [7:0] wlog [$];

    always #5 clk = ~clk;

    sprite_board_updater #(
        .BOARD_W      (4),
        .BOARD_H      (3),
        .NUM_SPRITES  (NS),
        .TYPE_W       (4),
        .FLOOR_TYPE   (4'h0),
        .SPRITE_TYPES (8'h43),
        .HOME_LOCS    (8'h51)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .next_loc  (next_loc),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .loc       (loc),
        .busy      (busy),
        .collision (collision)
    );

    always @(posedge clk) rom_data <= 4'(int'(rom_addr) % 16);

    always @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
            wlog.push_back({wr_addr, wr_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int a = 0; a < DEPTH; a++) ref_board[a] = a % 16;
        for (int k = 0; k < NS; k++) begin
            ref_board[home[k]] = stype[k];
            ref_loc[k] = home[k];
        end
    endtask

    task automatic check_state(input string tag);
        for (int a = 0; a < DEPTH; a++)
            chk($sformatf("%s board[%0d]", tag, a), 32'(ram[a]), 32'(ref_board[a]));
        chk({tag, " loc0"}, 32'(loc[3:0]), 32'(ref_loc[0]));
        chk({tag, " loc1"}, 32'(loc[7:4]), 32'(ref_loc[1]));
    endtask

    task automatic wait_init(input string tag);
        int cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " init cycles"}, cyc, DEPTH + 1 + NS);
        chk({tag, " init writes"}, wlog.size(), DEPTH + NS);
        for (int i = 0; i < DEPTH && i < wlog.size(); i++)
            chk($sformatf("%s init wr %0d", tag, i), 32'(wlog[i]), 32'({4'(i), 4'(i % 16)}));
        if (wlog.size() == DEPTH + NS) begin
            chk({tag, " place wr0"}, 32'(wlog[DEPTH]), 32'({4'(home[0]), 4'(stype[0])}));
            chk({tag, " place wr1"}, 32'(wlog[DEPTH+1]), 32'({4'(home[1]), 4'(stype[1])}));
        end
        model_init();
        check_state(tag);
    endtask

    task automatic run_tick(input string tag, input int n0, input int n1, input bit spurious,
                            output int fetch_ra);
        int s [NS];
        int exp_cyc = 1;
        int exp_coll = 0;
        int cyc = 0;
        int ncoll = 0;
        s[0] = n0;
        s[1] = n1;
        for (int i = 0; i < NS; i++) begin
            if (s[i] != ref_loc[i] && s[i] < DEPTH) begin
                ref_board[ref_loc[i]] = (UNDERLAY && i > 0) ? ref_loc[i] % 16 : 0;
                ref_board[s[i]] = stype[i];
                ref_loc[i] = s[i];
                exp_cyc += (UNDERLAY && i > 0) ? 6 : 5;
            end else begin
                exp_cyc += 2;
            end
        end
        for (int k = 1; k < NS; k++) if (ref_loc[k] == ref_loc[0]) exp_coll = 1;
        wlog.delete();
        fetch_ra = -1;
        next_loc = {4'(n1), 4'(n0)};
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (collision === 1'b1) ncoll++;
            if (cyc == 4) fetch_ra = int'(rom_addr);
            if (spurious && cyc == 2) begin
                tick = 1'b1;
                next_loc = 8'($urandom);
            end else begin
                tick = 1'b0;
                if (cyc == 3) next_loc = 8'($urandom);
            end
            @(negedge clk);
        end
        tick = 1'b0;
        chk({tag, " cycles"}, cyc, exp_cyc);
        chk({tag, " collision pulses"}, ncoll, exp_coll);
        check_state(tag);
    endtask

    initial begin
        int fra;
        int cyc;
        int nw;
        int n0;
        int n1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 1);
        chk("reset wr_en", 32'(wr_en), 0);
        chk("reset collision", 32'(collision), 0);
        chk("reset loc", 32'(loc), 32'h51);
        wlog.delete();
        reset = 1'b0;
        wait_init("init");

        // Pac-Man steps one tile, ghost stays
        run_tick("pac_step", 2, 5, 1'b0, fra);
        chk("pac_step nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("pac_step clear", 32'(wlog[0]), 32'h10);
            chk("pac_step draw", 32'(wlog[1]), 32'h23);
        end

        // Ghost moves 5 -> 6
        run_tick("ghost_step", 2, 6, 1'b0, fra);
        chk("ghost_step nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("ghost_step clear", 32'(wlog[0]), 32'({4'd5, UNDERLAY ? 4'd5 : 4'd0}));
            chk("ghost_step draw", 32'(wlog[1]), 32'h64);
        end
`ifdef SPRITE_UNDERLAY_EN
        chk("ghost_step fetch rom_addr", fra, 5);
`endif

        // Both land on tile 9: collision, ghost drawn last
        run_tick("meet", 9, 9, 1'b0, fra);
        chk("meet tile type", 32'(ram[9]), 4);

        // Out-of-range request plus a tick while busy
        run_tick("oob", DEPTH, 9, 1'b1, fra);
        chk("oob nwr", wlog.size(), 0);
        repeat (3) @(negedge clk);
        chk("busy tick not queued", 32'(busy), 0);

        // Randomised moves against the model
        for (int t = 0; t < 25; t++) begin
            n0 = ($urandom_range(0, 1) == 0) ? ref_loc[0] : int'($urandom_range(0, 15));
            n1 = ($urandom_range(0, 1) == 0) ? ref_loc[1] : int'($urandom_range(0, 15));
            run_tick($sformatf("rnd%0d", t), n0, n1, 1'(($urandom_range(0, 1))), fra);
        end

        // Restart in the middle of a DRAW
        next_loc = {4'(ref_loc[1]), 4'((ref_loc[0] + 1) % DEPTH)};
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        nw = 0;
        cyc = 0;
        while (nw < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (wr_en === 1'b1) nw++;
        end
        chk("abort reached draw", nw, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort wr_en", 32'(wr_en), 0);
        chk("abort busy", 32'(busy), 1);
        chk("abort loc", 32'(loc), 32'h51);
        wlog.delete();
        wait_init("restart");

        // One more move after the restart
        run_tick("post_restart", 0, 5, 1'b0, fra);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
